// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: round-robin arbiter sharing one AXI-stream sink among NUM_SRC sources with bounded bursts
module axis_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W = 32,
  parameter int MAX_BURST = 8,
  localparam int ID_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
) (
  input  logic                      s_aclk,
  input  logic                      s_areset,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
  output logic [NUM_SRC-1:0]        s_tready,
  input  logic                      m_tready,
  output logic                      m_tvalid,
  output logic [DATA_W-1:0]         m_tdata,
  output logic [ID_W-1:0]           m_tid,
  output logic [NUM_SRC-1:0]        o_grant
);
  localparam int BC_W = MAX_BURST > 0 ? $clog2(MAX_BURST + 1) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_d;
  logic [ID_W-1:0] gnt, gnt_d, ptr, ptr_d, win;
  logic [BC_W-1:0] bcnt, bcnt_d;
  logic [NUM_SRC-1:0] grant_d;
  logic busy, beat, rel;
  always_comb begin
    win = ptr;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (s_tvalid[(int'(ptr) + k) % NUM_SRC]) win = ID_W'((int'(ptr) + k) % NUM_SRC);
  end
  assign busy = state == GRANT;
  assign m_tvalid = !s_areset && busy && s_tvalid[gnt];
  assign beat = m_tvalid && m_tready;
  assign rel = busy && (!s_tvalid[gnt] || (MAX_BURST != 0 && beat && bcnt == BC_W'(MAX_BURST - 1)));
  assign s_tready = (!s_areset && busy && m_tready) ? NUM_SRC'(1) << gnt : '0;
  assign m_tdata = busy ? s_tdata[int'(gnt) * DATA_W +: DATA_W] : '0;
  assign m_tid = busy ? gnt : '0;
  always_comb begin
    state_d = state;
    gnt_d = gnt;
    ptr_d = ptr;
    bcnt_d = bcnt;
    grant_d = o_grant;
    if (!busy && |s_tvalid) begin
      state_d = GRANT;
      gnt_d = win;
      bcnt_d = '0;
      grant_d = NUM_SRC'(1) << win;
    end else if (rel) begin
      state_d = IDLE;
      ptr_d = gnt == ID_W'(NUM_SRC - 1) ? '0 : gnt + 1'b1;
      grant_d = '0;
    end else if (beat && bcnt != '1) begin
      bcnt_d = bcnt + 1'b1;
    end
  end
  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      state <= IDLE;
      gnt <= '0;
      ptr <= '0;
      bcnt <= '0;
      o_grant <= '0;
    end else begin
      state <= state_d;
      gnt <= gnt_d;
      ptr <= ptr_d;
      bcnt <= bcnt_d;
      o_grant <= grant_d;
    end
  end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed self-checking bench for a burst-limited and an unlimited arbiter instance
module tb_axis_rr_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic s_aclk = 1'b0;
  logic s_areset = 1'b1;
  logic [N-1:0] s_tvalid = '0;
  logic [N*W-1:0] s_tdata;
  logic a_mr = 1'b0, b_mr = 1'b0;
  logic [N-1:0] a_s_tready, b_s_tready, a_o_grant, b_o_grant;
  logic a_m_tvalid, b_m_tvalid;
  logic [W-1:0] a_m_tdata, b_m_tdata;
  logic [1:0] a_m_tid, b_m_tid;
  logic [15:0] seq [N] = '{default: 16'd0};
  int n_cmp = 0, n_err = 0;
  always #5 s_aclk = ~s_aclk;
  axis_rr_arbiter #(.NUM_SRC(N), .DATA_W(W), .MAX_BURST(2)) u_a (
    .s_aclk(s_aclk), .s_areset(s_areset), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
    .s_tready(a_s_tready), .m_tready(a_mr), .m_tvalid(a_m_tvalid), .m_tdata(a_m_tdata),
    .m_tid(a_m_tid), .o_grant(a_o_grant));
  axis_rr_arbiter #(.NUM_SRC(N), .DATA_W(W), .MAX_BURST(0)) u_b (
    .s_aclk(s_aclk), .s_areset(s_areset), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
    .s_tready(b_s_tready), .m_tready(b_mr), .m_tvalid(b_m_tvalid), .m_tdata(b_m_tdata),
    .m_tid(b_m_tid), .o_grant(b_o_grant));
  always @(posedge s_aclk)
    for (int i = 0; i < N; i++)
      if (s_tvalid[i] && (a_s_tready[i] || b_s_tready[i])) seq[i] <= seq[i] + 16'd1;
  always_comb
    for (int i = 0; i < N; i++) s_tdata[i*W +: W] = {16'(i), seq[i]};
  function automatic logic [31:0] d(input int s, input int q);
    return {16'(s), 16'(q)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge s_aclk);
    #1;
  endtask
  initial begin
    s_tvalid = 4'hF;
    a_mr = 1'b1;
    #4;
    chk("rst_a_tready0", 32'(a_s_tready), 0);
    chk("rst_a_tvalid0", 32'(a_m_tvalid), 0);
    cyc(); #3;
    chk("rst_a_tready1", 32'(a_s_tready), 0);
    chk("rst_a_tvalid1", 32'(a_m_tvalid), 0);
    cyc(); s_areset = 1'b0; #3;
    chk("post_rst_grant", 32'(a_o_grant), 0);
    chk("post_rst_tvalid", 32'(a_m_tvalid), 0);
    chk("post_rst_tid", 32'(a_m_tid), 0);
    chk("post_rst_tdata", a_m_tdata, 0);
    for (int c = 0; c < 14; c++) begin
      int p, k;
      cyc(); #3;
      p = c / 3;
      k = c % 3;
      if (k == 2) begin
        chk($sformatf("fair_bubble_v%0d", c), 32'(a_m_tvalid), 0);
        chk($sformatf("fair_bubble_g%0d", c), 32'(a_o_grant), 0);
      end else begin
        chk($sformatf("fair_v%0d", c), 32'(a_m_tvalid), 1);
        chk($sformatf("fair_tid%0d", c), 32'(a_m_tid), p % 4);
        chk($sformatf("fair_data%0d", c), a_m_tdata, d(p % 4, (p / 4) * 2 + k));
        chk($sformatf("fair_gnt%0d", c), 32'(a_o_grant), 1 << (p % 4));
      end
    end
    cyc(); a_mr = 1'b0; s_tvalid = 4'b0010; #3;
    chk("bp_bubble", 32'(a_m_tvalid), 0);
    for (int c = 0; c < 5; c++) begin
      cyc(); #3;
      chk($sformatf("bp_v%0d", c), 32'(a_m_tvalid), 1);
      chk($sformatf("bp_rdy%0d", c), 32'(a_s_tready), 0);
      chk($sformatf("bp_tid%0d", c), 32'(a_m_tid), 1);
      chk($sformatf("bp_data%0d", c), a_m_tdata, d(1, 2));
    end
    cyc(); a_mr = 1'b1; #3;
    chk("bp_go_rdy", 32'(a_s_tready), 4'b0010);
    chk("bp_go_data", a_m_tdata, d(1, 2));
    cyc(); #3;
    chk("bp_second_gnt", 32'(a_o_grant), 4'b0010);
    chk("bp_second_data", a_m_tdata, d(1, 3));
    cyc(); #3;
    chk("bp_release_gnt", 32'(a_o_grant), 0);
    chk("bp_release_v", 32'(a_m_tvalid), 0);
    cyc(); s_areset = 1'b1; s_tvalid = '0; a_mr = 1'b0; b_mr = 1'b1; #3;
    chk("rst_b_tready", 32'(b_s_tready), 0);
    chk("rst_b_tvalid", 32'(b_m_tvalid), 0);
    cyc(); s_areset = 1'b0; s_tvalid = 4'b0100; #3;
    chk("idle_b_gnt", 32'(b_o_grant), 0);
    for (int c = 0; c < 3; c++) begin
      cyc(); #3;
      chk($sformatf("idle_tid%0d", c), 32'(b_m_tid), 2);
      chk($sformatf("idle_v%0d", c), 32'(b_m_tvalid), 1);
      chk($sformatf("idle_data%0d", c), b_m_tdata, d(2, 2 + c));
    end
    cyc(); s_tvalid = 4'b1010; #3;
    chk("idle_drop_v", 32'(b_m_tvalid), 0);
    chk("idle_drop_gnt", 32'(b_o_grant), 4'b0100);
    cyc(); #3;
    chk("idle_bubble_gnt", 32'(b_o_grant), 0);
    chk("idle_bubble_v", 32'(b_m_tvalid), 0);
    cyc(); #3;
    chk("ptr3_tid", 32'(b_m_tid), 3);
    chk("ptr3_gnt", 32'(b_o_grant), 4'b1000);
    chk("ptr3_data", b_m_tdata, d(3, 2));
    cyc(); s_tvalid = '0; #3;
    chk("ptr3_drop_v", 32'(b_m_tvalid), 0);
    cyc(); s_tvalid = 4'b0011; #3;
    chk("mb0_idle_gnt", 32'(b_o_grant), 0);
    for (int c = 0; c < 20; c++) begin
      cyc(); #3;
      chk($sformatf("mb0_tid%0d", c), 32'(b_m_tid), 0);
      chk($sformatf("mb0_v%0d", c), 32'(b_m_tvalid), 1);
      chk($sformatf("mb0_data%0d", c), b_m_tdata, d(0, 4 + c));
    end
    cyc(); s_tvalid = 4'b0010; #3;
    chk("mb0_drop_v", 32'(b_m_tvalid), 0);
    cyc(); #3;
    chk("mb0_bubble_gnt", 32'(b_o_grant), 0);
    cyc(); s_tvalid = 4'b0011; #3;
    chk("mb0_src1_tid", 32'(b_m_tid), 1);
    chk("mb0_src1_gnt", 32'(b_o_grant), 4'b0010);
    chk("mb0_src1_data", b_m_tdata, d(1, 4));
    cyc(); s_areset = 1'b1; #3;
    chk("mid_rst_tready", 32'(b_s_tready), 0);
    chk("mid_rst_tvalid", 32'(b_m_tvalid), 0);
    cyc(); s_areset = 1'b0; #3;
    chk("mid_post_gnt", 32'(b_o_grant), 0);
    chk("mid_post_v", 32'(b_m_tvalid), 0);
    cyc(); #3;
    chk("mid_restart_tid", 32'(b_m_tid), 0);
    chk("mid_restart_gnt", 32'(b_o_grant), 4'b0001);
    chk("mid_restart_data", b_m_tdata, d(0, 24));
    cyc(); s_tvalid = 4'b0010; #3;
    chk("mid_drop_v", 32'(b_m_tvalid), 0);
    cyc(); #3;
    chk("mid_bubble_gnt", 32'(b_o_grant), 0);
    cyc(); #3;
    chk("mid_src1_tid", 32'(b_m_tid), 1);
    chk("mid_src1_data", b_m_tdata, d(1, 5));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
